// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding used by uart_tx and uart_rx, plus
// oversampling constants.
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int OS_TICKS = 16;
  localparam int MID_TICK = 7;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value selectable
// so idle-high lines come out of reset in their idle state.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, configurable data/stop length,
// registered byte output with one-cycle done and framing-error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] data_out,
  output logic       rx_done_tick,
  output logic       frame_err
);
  localparam int SW = (SB_TICK > 16) ? 5 : 4;

  uart_state_e   state, state_nx;
  logic [SW-1:0] s, s_nx;
  logic [2:0]    n, n_nx;
  logic [7:0]    shift, shift_nx, data_nx;
  logic          done_nx, ferr_nx;
  logic          rx_sync, rx_prev;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_sync)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      shift        <= '0;
      data_out     <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      rx_prev      <= 1'b1;
    end else begin
      state        <= state_nx;
      s            <= s_nx;
      n            <= n_nx;
      shift        <= shift_nx;
      data_out     <= data_nx;
      rx_done_tick <= done_nx;
      frame_err    <= ferr_nx;
      rx_prev      <= rx_sync;
    end
  end

  always_comb begin
    state_nx = state;
    s_nx     = s;
    n_nx     = n;
    shift_nx = shift;
    data_nx  = data_out;
    done_nx  = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      // Edge-triggered start: a line held low (break) never re-arms a frame.
      IDLE: if (rx_prev && !rx_sync) begin
        state_nx = START;
        s_nx     = '0;
      end
      START: if (s_tick) begin
        if (s == SW'(MID_TICK)) begin
          if (!rx_sync) begin
            state_nx = DATA;
            s_nx     = '0;
            n_nx     = '0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          s_nx = s + 1'b1;
        end
      end
      DATA: if (s_tick) begin
        if (s == SW'(OS_TICKS - 1)) begin
          s_nx     = '0;
          shift_nx = {rx_sync, shift[7:1]};
          if (n == 3'(DBIT - 1)) state_nx = STOP;
          else                   n_nx     = n + 1'b1;
        end else begin
          s_nx = s + 1'b1;
        end
      end
      STOP: if (s_tick) begin
        if (s == SW'(SB_TICK - 1)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          ferr_nx  = ~rx_sync;
          data_nx  = shift >> (8 - DBIT);
        end else begin
          s_nx = s + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an 8N1 instance and a 7-bit/2-stop instance share
// one oversampling tick generator whose spacing can be made irregular.
module tb_uart_rx;
  import uart_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  localparam int FRAME8 = 8 + 16 * 8 + 16;

  logic       clk = 1'b0, reset_n = 1'b0, s_tick = 1'b0, rx8 = 1'b1, rx7 = 1'b1;
  logic [7:0] dout8, dout7;
  logic       done8, done7, ferr8, ferr7;

  int   checks = 0, failures = 0;
  bit   jitter = 1'b0;
  int   tick_cnt = 0, edge_stamp = 0, last_ticks8 = -1;
  int   n_done8 = 0, n_done7 = 0;
  exp_t q8[$], q7[$];

  uart_rx #(.DBIT(8), .SB_TICK(16)) u_rx8 (
    .clk (clk), .reset_n (reset_n), .rx (rx8), .s_tick (s_tick),
    .data_out (dout8), .rx_done_tick (done8), .frame_err (ferr8)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32)) u_rx7 (
    .clk (clk), .reset_n (reset_n), .rx (rx7), .s_tick (s_tick),
    .data_out (dout7), .rx_done_tick (done7), .frame_err (ferr7)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Tick every 4 clocks, or every 1..6 clocks when jitter is on.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (cnt == 0) begin
        s_tick = 1'b1;
        cnt    = jitter ? int'($urandom_range(0, 5)) : 3;
      end else begin
        s_tick = 1'b0;
        cnt--;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    if (s_tick) tick_cnt++;
  end

  initial begin
    exp_t e;
    logic prev8 = 1'b0, prev7 = 1'b0;
    forever begin
      @(negedge clk);
      if (ferr8) chk("ferr8_with_done", done8, 1);
      if (ferr7) chk("ferr7_with_done", done7, 1);
      if (done8) begin
        n_done8++;
        last_ticks8 = tick_cnt - edge_stamp;
        chk("done8_1clk", prev8, 0);
        chk("sb8_expected", q8.size() != 0, 1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          chk("data8", dout8, e.data);
          chk("ferr8", ferr8, e.ferr);
        end
      end
      if (done7) begin
        n_done7++;
        chk("done7_1clk", prev7, 0);
        chk("sb7_expected", q7.size() != 0, 1);
        if (q7.size() != 0) begin
          e = q7.pop_front();
          chk("data7", dout7, e.data);
          chk("ferr7", ferr7, e.ferr);
        end
      end
      prev8 = done8;
      prev7 = done7;
    end
  end

  task automatic wait_tick;
    do @(posedge clk); while (s_tick !== 1'b1);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 8) rx8 = v;
    else            rx7 = v;
  endtask

  task automatic send(input int which, input logic [7:0] d, input int nbits,
                      input int stop_hi, input int stop_lo);
    set_rx(which, 1'b0);
    edge_stamp = tick_cnt;
    ticks(16);
    for (int i = 0; i < nbits; i++) begin
      set_rx(which, d[i]);
      ticks(16);
    end
    set_rx(which, 1'b1);
    ticks(stop_hi);
    if (stop_lo > 0) begin
      set_rx(which, 1'b0);
      ticks(stop_lo);
    end
  endtask

  initial begin
    int nd;
    repeat (3) @(negedge clk);
    chk("rst_dout8", dout8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_ferr8", ferr8, 0);
    chk("rst_state8", 32'(u_rx8.state), 32'(IDLE));
    chk("rst_dout7", dout7, 0);
    reset_n = 1'b1;
    ticks(4);

    // Plain 8N1 frame with latency measured in ticks from the start edge.
    q8.push_back('{data: 8'hA5, ferr: 1'b0});
    send(8, 8'hA5, 8, 16, 0);
    chk("frame8_ticks", last_ticks8, FRAME8);
    chk("n_done8_a5", n_done8, 1);
    ticks(4);

    // Reset asserted mid-DATA takes effect without a clock edge.
    rx8 = 1'b0;
    ticks(16 + 40);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_dout8", dout8, 0);
    chk("arst_done8", done8, 0);
    chk("arst_ferr8", ferr8, 0);
    chk("arst_state8", 32'(u_rx8.state), 32'(IDLE));
    rx8 = 1'b1;
    ticks(5);
    @(negedge clk);
    reset_n = 1'b1;
    ticks(40);
    chk("arst_no_done", n_done8, 1);

    // Short low pulse is rejected; the following frame is still clean.
    rx8 = 1'b0;
    ticks(5);
    rx8 = 1'b1;
    ticks(30);
    chk("glitch_no_done", n_done8, 1);
    chk("glitch_state", 32'(u_rx8.state), 32'(IDLE));
    q8.push_back('{data: 8'h3C, ferr: 1'b0});
    send(8, 8'h3C, 8, 16, 0);
    ticks(4);

    // Stop bit low, line then held low: one error pulse, no re-trigger.
    nd = n_done8;
    q8.push_back('{data: 8'h00, ferr: 1'b1});
    send(8, 8'h00, 8, 0, 16 + 200);
    chk("break_one_done", n_done8, nd + 1);
    chk("break_hold8", dout8, 8'h00);
    rx8 = 1'b1;
    ticks(20);

    // Back-to-back; the shortened stop before 0x01 puts its start edge
    // right after the receiver returns to idle.
    nd = n_done8;
    q8.push_back('{data: 8'h55, ferr: 1'b0});
    q8.push_back('{data: 8'hFF, ferr: 1'b0});
    q8.push_back('{data: 8'h01, ferr: 1'b0});
    send(8, 8'h55, 8, 16, 0);
    send(8, 8'hFF, 8, 8, 0);
    send(8, 8'h01, 8, 16, 0);
    ticks(4);
    chk("b2b_done_cnt", n_done8, nd + 3);
    chk("b2b_hold8", dout8, 8'h01);

    // Irregular tick spacing on both instances.
    jitter = 1'b1;
    q7.push_back('{data: 8'h7F, ferr: 1'b0});
    send(7, 8'h7F, 7, 32, 0);
    q7.push_back('{data: 8'h2A, ferr: 1'b1});
    send(7, 8'h2A, 7, 16, 24);
    rx7 = 1'b1;
    ticks(20);
    q7.push_back('{data: 8'h55, ferr: 1'b0});
    send(7, 8'h55, 7, 32, 0);
    q8.push_back('{data: 8'h96, ferr: 1'b0});
    send(8, 8'h96, 8, 16, 0);
    ticks(8);
    chk("n_done7", n_done7, 3);
    chk("hold7", dout7, 8'h55);
    chk("sb8_drained", q8.size(), 0);
    chk("sb7_drained", q7.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
